// File: rtl/dm_line_port.sv
// dm_line_port: CPU-side initiator for a 256-bit line-wide data memory.
// Single-word loads/stores go through a one-entry write-back line buffer;
// misses fill the buffer from memory and evict a dirty line first.
// Latency from accept cycle to resp_valid: hit 2, clean miss 3, dirty miss 4.
// Requests are refused (req_ready=0) while busy or while flush_req is high.
// Responses have no backpressure.
// Ports:
//   clk, rst                              clock, async active-high reset
//   req_valid/req_ready/req_we/addr/wdata word request handshake from the LSU
//   resp_valid, resp_rdata                one-cycle completion pulse and load data
//   flush_req, flush_done                 write back a dirty buffer on demand
//   dm_raddr/dm_rdata                     combinational line read port
//   dm_wen/dm_waddr/dm_wdata              line write port
module dm_line_port #(
  parameter int LINE_AW = 12,
  parameter int WORD_W  = 16,
  parameter int WORDS   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [LINE_AW+3:0]        req_addr,
  input  logic [WORD_W-1:0]         req_wdata,
  output logic                      resp_valid,
  output logic [WORD_W-1:0]         resp_rdata,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [LINE_AW-1:0]        dm_raddr,
  input  logic [WORD_W*WORDS-1:0]   dm_rdata,
  output logic                      dm_wen,
  output logic [LINE_AW-1:0]        dm_waddr,
  output logic [WORD_W*WORDS-1:0]   dm_wdata
);

  typedef enum logic [1:0] {IDLE, FLUSH, FILL, RESP} state_t;

  state_t              state_q;
  logic                buf_valid_q;
  logic                buf_dirty_q;
  logic [LINE_AW-1:0]  buf_tag_q;
  logic [WORD_W-1:0]   buf_w_q [WORDS];

  // Latched request; op_flush_q tells FLUSH whether it was started by
  // flush_req (return to IDLE) or by a dirty miss (continue to FILL).
  logic                op_flush_q;
  logic                lat_we_q;
  logic [LINE_AW+3:0]  lat_addr_q;
  logic [WORD_W-1:0]   lat_wdata_q;

  logic                resp_valid_q;
  logic [WORD_W-1:0]   resp_rdata_q;
  logic                flush_done_q;

  logic [LINE_AW-1:0]  req_line;
  logic [LINE_AW-1:0]  lat_line;
  logic [3:0]          lat_idx;
  logic                hit;
  logic                accept;

  assign req_line = req_addr[LINE_AW+3:4];
  assign lat_line = lat_addr_q[LINE_AW+3:4];
  assign lat_idx  = lat_addr_q[3:0];
  assign hit      = buf_valid_q && (buf_tag_q == req_line);

  // flush_req has priority, so it also closes the request handshake.
  assign req_ready = !rst && (state_q == IDLE) && !flush_req;
  assign accept    = req_valid && req_ready;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign flush_done = flush_done_q;

  // Read address tracks the latched line at all times; only FILL consumes it.
  assign dm_raddr = lat_line;
  assign dm_waddr = buf_tag_q;
  // Decoded from registered state only, so an async reset drops it at once.
  assign dm_wen   = (state_q == FLUSH);

  // Write port packs word 0 into the LSBs (read port uses the opposite order).
  always_comb begin
    dm_wdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      dm_wdata[WORD_W*i +: WORD_W] = buf_w_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_valid_q  <= 1'b0;
      buf_dirty_q  <= 1'b0;
      buf_tag_q    <= '0;
      for (int i = 0; i < WORDS; i++) begin
        buf_w_q[i] <= '0;
      end
      op_flush_q   <= 1'b0;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      flush_done_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            if (buf_valid_q && buf_dirty_q) begin
              op_flush_q <= 1'b1;
              state_q    <= FLUSH;
            end else begin
              flush_done_q <= 1'b1;
            end
          end else if (accept) begin
            op_flush_q  <= 1'b0;
            lat_we_q    <= req_we;
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            if (hit) begin
              state_q <= RESP;
            end else if (buf_valid_q && buf_dirty_q) begin
              state_q <= FLUSH;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FLUSH: begin
          buf_dirty_q <= 1'b0;
          if (op_flush_q) begin
            flush_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            state_q <= FILL;
          end
        end
        FILL: begin
          // Memory presents word 0 in the MSBs.
          for (int i = 0; i < WORDS; i++) begin
            buf_w_q[i] <= dm_rdata[WORD_W*(WORDS-i)-1 -: WORD_W];
          end
          buf_tag_q   <= lat_line;
          buf_valid_q <= 1'b1;
          buf_dirty_q <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (lat_we_q) begin
            buf_w_q[lat_idx] <= lat_wdata_q;
            buf_dirty_q      <= 1'b1;
            resp_rdata_q     <= '0;
          end else begin
            resp_rdata_q <= buf_w_q[lat_idx];
          end
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_line_port.sv
module tb_dm_line_port;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [15:0]  req_addr, req_wdata;
  logic         resp_valid;
  logic [15:0]  resp_rdata;
  logic         flush_req, flush_done;
  logic [11:0]  dm_raddr, dm_waddr;
  logic [255:0] dm_rdata, dm_wdata;
  logic         dm_wen;

  always #5 clk = ~clk;

  dm_line_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .dm_wen(dm_wen), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata)
  );

  // Memory seen by the DUT (word addressed).
  logic [15:0] mem  [0:65535];
  // Reference: mmem = what memory must hold, gold = architectural word values.
  logic [15:0] mmem [0:65535];
  logic [15:0] gold [0:65535];
  logic        mv, md;
  logic [11:0] mtag;

  int checks = 0;
  int errors = 0;

  always_comb begin
    dm_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      dm_rdata[255-16*i -: 16] = mem[{dm_raddr, 4'(i)}];
    end
  end

  always @(posedge clk) begin
    if (dm_wen) begin
      for (int i = 0; i < 16; i++) begin
        mem[{dm_waddr, 4'(i)}] <= dm_wdata[16*i +: 16];
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v; mmem[a] = v; gold[a] = v;
  endtask

  // Architectural line contents, word 0 in LSBs (write-port order).
  function automatic logic [255:0] gold_line(input logic [11:0] ln);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = gold[{ln, 4'(i)}];
    return r;
  endfunction

  task automatic commit_line(input logic [11:0] ln);
    for (int i = 0; i < 16; i++) mmem[{ln, 4'(i)}] = gold[{ln, 4'(i)}];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      chk("idle_rdy", req_ready, 1'b1);
      chk("idle_resp", resp_valid, 1'b0);
      chk("idle_wen", dm_wen, 1'b0);
      chk("idle_fdone", flush_done, 1'b0);
    end
  endtask

  task automatic do_op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       output logic [15:0] rd, output int lat, output int wb_n,
                       output logic [11:0] wb_a, output logic [255:0] wb_d);
    logic [11:0] ln;
    logic hit, dmiss;
    int elat, fcyc;
    logic [255:0] ewb;
    logic [15:0] erd;
    ln    = addr[15:4];
    hit   = mv && (mtag == ln);
    dmiss = !hit && mv && md;
    elat  = hit ? 2 : (dmiss ? 4 : 3);
    fcyc  = hit ? 0 : (dmiss ? 2 : 1);
    ewb   = gold_line(mtag);
    erd   = we ? 16'h0 : gold[addr];
    rd = '0; lat = 0; wb_n = 0; wb_a = '0; wb_d = '0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    #1;
    chk("accept_rdy", req_ready, 1'b1);
    for (int k = 1; k <= elat; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      #1;
      chk("busy_rdy", req_ready, k == elat);
      chk("resp_vld", resp_valid, k == elat);
      chk("wen", dm_wen, dmiss && (k == 1));
      if (dm_wen) begin
        wb_n++; wb_a = dm_waddr; wb_d = dm_wdata;
        chk("wb_addr", dm_waddr, mtag);
        chk("wb_data", dm_wdata, ewb);
      end
      if (k == fcyc) chk("fill_raddr", dm_raddr, ln);
      if (resp_valid && lat == 0) begin
        lat = k; rd = resp_rdata;
      end
      if (k == elat) chk("rdata", resp_rdata, erd);
    end
    if (!hit) begin
      if (dmiss) commit_line(mtag);
      mv = 1'b1; mtag = ln; md = 1'b0;
    end
    if (we) begin
      gold[addr] = wd; md = 1'b1;
    end
  endtask

  task automatic do_flush(input logic with_req, output int wb_n,
                          output logic [255:0] wb_d, output int done_cyc);
    logic dirty;
    int edone;
    logic [255:0] ewb;
    dirty = mv && md;
    edone = dirty ? 2 : 1;
    ewb   = gold_line(mtag);
    wb_n = 0; wb_d = '0; done_cyc = 0;
    flush_req = 1'b1; req_valid = with_req;
    req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    #1;
    chk("flush_rdy", req_ready, 1'b0);
    for (int k = 1; k <= edone; k++) begin
      @(negedge clk);
      flush_req = 1'b0; req_valid = 1'b0;
      #1;
      chk("fdone", flush_done, k == edone);
      if (flush_done && done_cyc == 0) done_cyc = k;
      chk("f_wen", dm_wen, dirty && (k == 1));
      if (dm_wen) begin
        wb_n++; wb_d = dm_wdata;
        chk("f_waddr", dm_waddr, mtag);
        chk("f_wdata", dm_wdata, ewb);
      end
      chk("f_resp", resp_valid, 1'b0);
      chk("f_rdy", req_ready, k == edone);
    end
    if (dirty) begin
      commit_line(mtag); md = 1'b0;
    end
  endtask

  initial begin
    logic [15:0]  rd;
    int           lat, wb_n, done_c;
    logic [11:0]  wb_a;
    logic [255:0] wb_d;
    logic [11:0]  ln;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush_req = 1'b0;
    mv = 1'b0; md = 1'b0; mtag = '0;
    for (int w = 0; w < 65536; w++) set_word(16'(w), 16'($urandom));
    #1 rst = 1'b1;
    #11;
    chk("rst_rdy", req_ready, 1'b0);
    chk("rst_resp", resp_valid, 1'b0);
    chk("rst_fdone", flush_done, 1'b0);
    chk("rst_wen", dm_wen, 1'b0);
    chk("rst_raddr", dm_raddr, 12'h000);
    chk("rst_waddr", dm_waddr, 12'h000);
    chk("rst_wdata", dm_wdata, 256'h0);
    chk("rst_rdata", resp_rdata, 16'h0);
    @(negedge clk); rst = 1'b0; #1;

    // Cold load: clean miss fills line 0x012.
    set_word(16'h0123, 16'hBEEF);
    do_op(1'b0, 16'h0123, 16'h0, rd, lat, wb_n, wb_a, wb_d);
    chk("t1_rdata", rd, 16'hBEEF);
    chk("t1_lat", lat, 3);
    chk("t1_wb", wb_n, 0);

    // Store then load same word: both hits.
    do_op(1'b1, 16'h0125, 16'h1234, rd, lat, wb_n, wb_a, wb_d);
    chk("t2_st_lat", lat, 2);
    chk("t2_st_rdata", rd, 16'h0);
    do_op(1'b0, 16'h0125, 16'h0, rd, lat, wb_n, wb_a, wb_d);
    chk("t2_ld_lat", lat, 2);
    chk("t2_ld_rdata", rd, 16'h1234);
    chk("t2_wb", wb_n, 0);

    // Dirty miss evicts line 0x012.
    do_op(1'b0, 16'h0450, 16'h0, rd, lat, wb_n, wb_a, wb_d);
    chk("t3_lat", lat, 4);
    chk("t3_wb_n", wb_n, 1);
    chk("t3_waddr", wb_a, 12'h012);
    chk("t3_word5", wb_d[95:80], 16'h1234);

    // Word order on the write port.
    for (int i = 0; i < 16; i++) set_word({12'h300, 4'(i)}, 16'(i));
    do_op(1'b1, 16'h3000, 16'hAAAA, rd, lat, wb_n, wb_a, wb_d);
    chk("t4_lat", lat, 3);
    do_flush(1'b0, wb_n, wb_d, done_c);
    chk("t4_wb_n", wb_n, 1);
    chk("t4_wdata", wb_d,
        256'h000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001_AAAA);
    chk("t4_done", done_c, 2);

    // Flush and request together on a dirty buffer, then clean flush.
    do_op(1'b1, 16'h3007, 16'h5555, rd, lat, wb_n, wb_a, wb_d);
    do_flush(1'b1, wb_n, wb_d, done_c);
    chk("t5_wb_n", wb_n, 1);
    chk("t5_done", done_c, 2);
    do_op(1'b0, 16'h3007, 16'h0, rd, lat, wb_n, wb_a, wb_d);
    chk("t5_rdata", rd, 16'h5555);
    chk("t5_lat", lat, 2);
    do_flush(1'b0, wb_n, wb_d, done_c);
    chk("t5_clean_wb", wb_n, 0);
    chk("t5_clean_done", done_c, 1);

    // Reset in the middle of a write-back discards the dirty line.
    do_op(1'b1, 16'h3002, 16'h7777, rd, lat, wb_n, wb_a, wb_d);
    flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0; #1;
    chk("t6_wen_pre", dm_wen, 1'b1);
    rst = 1'b1; #1;
    chk("t6_wen_rst", dm_wen, 1'b0);
    chk("t6_rdy_rst", req_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) gold[{mtag, 4'(i)}] = mmem[{mtag, 4'(i)}];
    mv = 1'b0; md = 1'b0;
    #1;
    do_op(1'b0, 16'h3002, 16'h0, rd, lat, wb_n, wb_a, wb_d);
    chk("t6_lat", lat, 3);
    chk("t6_rdata", rd, 16'h0002);

    // Random traffic over a small line pool (incl. 0xFFF) for hits and evictions.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: ln = 12'h000;
        1: ln = 12'h012;
        2: ln = 12'hFFF;
        3: ln = 12'h045;
        4: ln = 12'h300;
        default: ln = 12'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0)
        do_flush(1'($urandom), wb_n, wb_d, done_c);
      else
        do_op(1'($urandom), {ln, 4'($urandom)}, 16'($urandom), rd, lat, wb_n, wb_a, wb_d);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
